// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave
// AXI4 slave endpoint backed by a word-addressed internal RAM. Services one
// transaction at a time (write or read), INCR/FIXED bursts, byte strobes,
// and range-checked error responses.
//
// Ports:
//   aclk, aresetn      : clock; synchronous active-low reset
//   s_axi_aw*          : write address channel (lock/cache/prot/region/qos ignored)
//   s_axi_w*           : write data channel
//   s_axi_b*           : write response channel
//   s_axi_ar*          : read address channel (lock/cache/prot/region/qos ignored)
//   s_axi_r*           : read data channel
//   fsm_state          : debug view of the controller state (IDLE/WDATA/WRESP/RDATA)
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// both valid and ready are high. A valid, once raised by this block, stays high
// with its payload unchanged until the matching ready is seen.
module axi4_mem_slave #(
    parameter int MEM_DEPTH     = 1024,
    parameter bit RD_PRIO_RESET = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awregion,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arregion,
    input  logic [3:0]  s_axi_arqos,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_t;

    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(MEM_DEPTH);

    logic [31:0] mem [MEM_DEPTH];

    state_t      state_q, state_d;
    logic        prio_q;        // 0: write side wins a tie, 1: read side wins
    logic [31:0] addr_q;        // write: current beat address; read: next beat address
    logic [7:0]  len_q, cnt_q;
    logic        fixed_q, illegal_q, werr_q, dec_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;

    logic        aw_go, ar_go, w_go, w_end, r_go, r_end;
    logic [31:0] rd_addr, rd_word;
    logic        rd_illegal;
    logic [1:0]  rd_resp;

    function automatic logic in_range(input logic [29:0] idx);
        return idx < DEPTH_LIM;
    endfunction

    function automatic logic bad_txn(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == 2'b00 || burst == 2'b01) || (size != 3'd2);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic fixed);
        return fixed ? a : a + 32'd4;
    endfunction

    assign aw_go = s_axi_awvalid && s_axi_awready;
    assign ar_go = s_axi_arvalid && s_axi_arready;
    assign w_go  = (state_q == WDATA) && s_axi_wvalid;
    // An early wlast ends the burst at that beat; it is also flagged as an error.
    assign w_end = w_go && ((cnt_q == len_q) || s_axi_wlast);
    assign r_go  = (state_q == RDATA) && s_axi_rready;
    assign r_end = r_go && rlast_q;

    // Read beat source: in IDLE the AR request itself supplies beat 0, so the
    // first beat is registered on the AR handshake and is valid one cycle later.
    always_comb begin
        rd_addr    = (state_q == IDLE) ? s_axi_araddr : addr_q;
        rd_illegal = (state_q == IDLE) ? bad_txn(s_axi_arburst, s_axi_arsize) : illegal_q;
        rd_resp    = 2'b00;
        rd_word    = 32'd0;
        if (rd_illegal) begin
            rd_resp = 2'b10;
        end else if (!in_range(rd_addr[31:2])) begin
            rd_resp = 2'b11;
        end else begin
            rd_word = mem[rd_addr[IDX_W+1:2]];
        end
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (aw_go) state_d = WDATA;
                   else if (ar_go) state_d = RDATA;
            WDATA: if (w_end) state_d = WRESP;
            WRESP: if (s_axi_bready) state_d = IDLE;
            RDATA: if (r_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        s_axi_rvalid  = 1'b0;
        unique case (state_q)
            IDLE: if (aresetn) begin
                // At most one ready: on a tie the priority owner is granted.
                s_axi_awready = s_axi_awvalid && (!s_axi_arvalid || !prio_q);
                s_axi_arready = s_axi_arvalid && (!s_axi_awvalid || prio_q);
            end
            WDATA: s_axi_wready = 1'b1;
            WRESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = (illegal_q || werr_q) ? 2'b10 : (dec_q ? 2'b11 : 2'b00);
            end
            RDATA: s_axi_rvalid = 1'b1;
            default: ;
        endcase
    end

    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rlast = rlast_q;
    assign fsm_state   = state_q;

    // Transaction datapath
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prio_q    <= RD_PRIO_RESET;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            fixed_q   <= 1'b0;
            illegal_q <= 1'b0;
            werr_q    <= 1'b0;
            dec_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            if (aw_go || ar_go) prio_q <= ~prio_q;
            if (aw_go) begin
                addr_q    <= s_axi_awaddr;
                len_q     <= s_axi_awlen;
                cnt_q     <= 8'd0;
                fixed_q   <= (s_axi_awburst == 2'b00);
                illegal_q <= bad_txn(s_axi_awburst, s_axi_awsize);
                werr_q    <= 1'b0;
                dec_q     <= 1'b0;
            end
            if (ar_go) begin
                addr_q    <= step(s_axi_araddr, s_axi_arburst == 2'b00);
                len_q     <= s_axi_arlen;
                cnt_q     <= 8'd0;
                fixed_q   <= (s_axi_arburst == 2'b00);
                illegal_q <= rd_illegal;
                rdata_q   <= rd_word;
                rresp_q   <= rd_resp;
                rlast_q   <= (s_axi_arlen == 8'd0);
            end
            if (w_go) begin
                if (!in_range(addr_q[31:2])) dec_q <= 1'b1;
                if (s_axi_wlast != (cnt_q == len_q)) werr_q <= 1'b1;
                addr_q <= step(addr_q, fixed_q);
                if (!w_end) cnt_q <= cnt_q + 8'd1;
            end
            if (r_go) begin
                if (rlast_q) begin
                    rdata_q <= 32'd0;
                    rresp_q <= 2'b00;
                    rlast_q <= 1'b0;
                end else begin
                    rdata_q <= rd_word;
                    rresp_q <= rd_resp;
                    rlast_q <= ((cnt_q + 8'd1) == len_q);
                    cnt_q   <= cnt_q + 8'd1;
                    addr_q  <= step(addr_q, fixed_q);
                end
            end
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (aresetn && w_go && !illegal_q && in_range(addr_q[31:2])) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion, s_axi_awqos,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arregion, s_axi_arqos,
                           rd_addr[1:0]};

endmodule

// File: doc/axi4_mem_slave.md
# axi4_mem_slave

AXI4 memory-mapped slave endpoint with internal word-addressed RAM, placed directly downstream of the AXI pass-through DUT: its slave port binds to the DUT's `m_axi_*` master signals in the verification environment. It is the terminating target the DUT's forwarded bursts land in. It services one transaction at a time (write or read) with INCR/FIXED bursts, byte strobes and range-checked error responses, so scoreboards can compare end-to-end data.

## Interface
- `MEM_DEPTH`, 1024: number of 32-bit words; index = `addr[31:2]`
- `RD_PRIO_RESET`, 0: arbitration owner after reset (0 = write first)

Ports; AXI signal widths are those of the DUT's 32-bit AXI4 port:
- `aclk` in 1: single clock, all logic on rising edge
- `aresetn` in 1: reset is synchronous and active-low
- `s_axi_awaddr` in 32, `s_axi_awlen` in 8, `s_axi_awsize` in 3, `s_axi_awburst` in 2, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel
- `s_axi_awlock`/`awcache`/`awprot`/`awregion`/`awqos` in: accepted, ignored
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wlast` in 1, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response
- `s_axi_araddr` in 32, `s_axi_arlen` in 8, `s_axi_arsize` in 3, `s_axi_arburst` in 2, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address (lock/cache/prot/region/qos ignored)
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rlast` out 1, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data

## Operation
- FSM: IDLE, WDATA, WRESP, RDATA.
- IDLE: `awready`/`arready` combinational from state and valids. Only aw valid → `awready`=1. Only ar valid → `arready`=1. Both valid → grant the side owning priority. Priority flips after every grant (alternation). Never both readies high.
- AW handshake: latch addr, len, burst, and size check → WDATA. AR handshake: same latches → RDATA.
- Address step per beat: INCR +4; FIXED +0. Low two address bits ignored (word-aligned).
- Error flag latched per transaction:
  - SLVERR (2'b10) if burst == WRAP/reserved, or size != 2.
  - DECERR (2'b11) if any beat's index >= MEM_DEPTH.
  - SLVERR takes precedence over DECERR.
- WDATA: `wready`=1. Each beat writes the bytes enabled by `wstrb` to mem[index], only if index is in range and burst/size are legal. Beat counter counts up to len.
  - The beat with count == len ends the burst → WRESP.
  - `wlast` mismatch (asserted early, or absent on the final beat) → SLVERR. On an early `wlast`, the burst ends at that beat.
- WRESP: `bvalid`=1, `bresp` = OKAY/SLVERR/DECERR. Hold until `bready` → IDLE.
- RDATA: `rvalid`=1 with registered `rdata`/`rresp`. `rlast`=1 on beat len. On a handshake with `rlast` → IDLE.
  - Out-of-range or illegal beats return `rdata`=0, and `rresp` is set per beat.
- Memory is not reset. Contents survive reset.

## Timing
- Reset (`aresetn`=0 at an edge): state IDLE, priority = `RD_PRIO_RESET`. All outputs 0 from the next cycle: ready/valid, `bresp`, `rresp`, `rdata`, `rlast`.
- Reset mid-burst aborts it. Writes already committed stay in memory. No response is issued.
- Write: AW handshake at cycle N → `wready`=1 from N+1. Last W handshake at M → `bvalid`=1 at M+1. Zero-cycle bubble between beats.
- Read: AR handshake at N → beat 0 `rvalid` at N+1. Handshake of beat k at M → beat k+1 valid at M+1 (full throughput). `rvalid`/`rdata`/`rresp`/`rlast` stable while `rready`=0.
- After `bvalid`/`rlast` handshake at cycle M: IDLE at M+1, earliest next ready at M+1.
- `awlen`/`arlen` = 255 → 256 beats. Counter is 8-bit and never wraps past len.
- An address that would pass 2^32 wraps modulo 2^32, then is range-checked.

## Test plan
- Single write 0x100 data 0xDEADBEEF strb 0xF, then read 0x100 → `bresp`=0, `rdata`=0xDEADBEEF, `rresp`=0, `rlast`=1 on beat 0.
- INCR write len=3 at 0x40 data 1..4, strb 0x3 on beat 2 over prior 0xFFFFFFFF; read back → 1,2,0xFFFF0003,4. Throughput one beat/cycle with `rready` held. `rlast` only on beat 3.
- FIXED write len=1 at 0x20 data 0xA then 0xB → mem[8]=0xB. WRAP write → `bresp`=2'b10 and memory unchanged. `awsize`=1 → SLVERR.
- Read len=1 at (MEM_DEPTH-1)*4 → beat 0 OKAY with data, beat 1 `rresp`=2'b11, `rdata`=0. Matching write → `bresp`=2'b11 and in-range beat written.
- `awvalid` and `arvalid` asserted together repeatedly → grants alternate W,R,W,… from reset. Random `rready`/`bready` stalls keep outputs stable.
- Assert `aresetn`=0 mid 8-beat read after beat 3 → `rvalid`=0 next cycle. A subsequent read sees data intact.
